axi_slv_wr_responder: RTL and testbench

//  Testbench-side AXI write slave that terminates the master write-data driver's AW/W/B traffic.

---
 rtl/axi_tb_pkg.sv | 20 ++
 rtl/axi_slv_ostd_fifo.sv | 54 +++++
 rtl/axi_slv_wr_responder.sv | 142 ++++++++++++++
 tb/tb_axi_slv_wr_responder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_tb_pkg.sv
// Shared types for the AXI write-slave responder: response codes, the
// queued AW entry layout and the stall LFSR seed.
package axi_tb_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } axi_resp_e;

    // Widest AW id the queue entry can carry; narrower ids are zero-extended.
    localparam int AXI_ID_MAX_W = 8;

    typedef struct packed {
        logic [AXI_ID_MAX_W-1:0] id;
        logic [7:0]              len;
    } aw_ent_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/axi_slv_ostd_fifo.sv
// Small synchronous FIFO used for the outstanding AW and B queues.
// The head entry is presented combinationally; a push is taken when the
// queue is not full, or when it is full but is popped in the same cycle.
module axi_slv_ostd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             aclk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign head  = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge aclk) begin
        if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axi_slv_wr_responder.sv
// AXI write slave that terminates AW/W/B traffic from a master driver.
// AW requests are queued; W beats are consumed against the oldest AW, the
// burst is checked for length and id, and one B is queued per burst.
// Optional feature macro: SLV_RAND_STALL_EN adds LFSR-driven ready stalls.
// Handshakes: a transfer happens on every rising aclk where valid and ready
// are both high; valid never depends on ready, and B id/resp hold steady
// while bvalid is high and bready is low.
module axi_slv_wr_responder
    import axi_tb_pkg::*;
#(
    parameter int AXI_ID_W        = 4,
    parameter int AXI_DATA_W      = 32,
    parameter int SLV_OSTDREQ_NUM = 4
) (
    input  logic                    aclk,
    input  logic                    srst,
    input  logic                    in_awvalid,
    output logic                    out_awready,
    input  logic [AXI_ID_W-1:0]     in_awid,
    input  logic [7:0]              in_awlen,
    input  logic                    in_wvalid,
    output logic                    out_wready,
    input  logic [AXI_ID_W-1:0]     in_wid,
    input  logic [AXI_DATA_W-1:0]   in_wdata,
    input  logic [AXI_DATA_W/8-1:0] in_wstrb,
    input  logic                    in_wlast,
    output logic                    out_bvalid,
    input  logic                    in_bready,
    output logic [AXI_ID_W-1:0]     out_bid,
    output logic [1:0]              out_bresp,
    output logic [AXI_DATA_W-1:0]   data_sum,
    output logic [15:0]             err_cnt
);

    localparam int STRB_W = AXI_DATA_W / 8;
    localparam int B_W    = AXI_ID_W + 2;

    aw_ent_t         aw_push_ent;
    aw_ent_t         aw_head;
    logic            aw_push, aw_pop, aw_full, aw_empty;
    logic [B_W-1:0]  b_push_ent, b_head;
    logic            b_push, b_pop, b_full, b_empty;
    logic [7:0]      beat_cnt;
    logic            burst_err;
    logic            aw_go, w_go;
    logic            w_fire, at_len, id_bad, beat_err;
    axi_resp_e       b_resp;
    logic [AXI_DATA_W-1:0] wmask;

`ifdef SLV_RAND_STALL_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign aw_go   = lfsr[0];
    assign w_go    = lfsr[1];

    // Free-running stall pattern generator, restarted on every reset.
    always_ff @(posedge aclk) begin
        if (srst) lfsr <= LFSR_SEED;
        else      lfsr <= {lfsr_fb, lfsr[15:1]};
    end
`else
    assign aw_go = 1'b1;
    assign w_go  = 1'b1;
`endif

    assign out_awready = !srst && !aw_full && aw_go;
    assign out_wready  = !srst && !aw_empty && !b_full && w_go;

    assign aw_push        = in_awvalid && out_awready;
    assign aw_push_ent.id  = AXI_ID_MAX_W'(in_awid);
    assign aw_push_ent.len = in_awlen;

    // A beat closes the burst on wlast or when it is the beat the AW asked for
    // last; early, late and wrong-id beats all poison the burst response.
    assign w_fire   = in_wvalid && out_wready;
    assign at_len   = (beat_cnt == aw_head.len);
    assign id_bad   = (aw_head.id != AXI_ID_MAX_W'(in_wid));
    assign beat_err = id_bad || (in_wlast && !at_len) || (!in_wlast && at_len);
    assign aw_pop   = w_fire && (in_wlast || at_len);
    assign b_push   = aw_pop;
    assign b_resp   = (burst_err || beat_err) ? RESP_SLVERR : RESP_OKAY;
    assign b_push_ent = {aw_head.id[AXI_ID_W-1:0], b_resp};

    assign b_pop      = out_bvalid && in_bready;
    assign out_bvalid = !b_empty;
    assign out_bid    = b_head[B_W-1:2];
    assign out_bresp  = b_head[1:0];

    // Expand byte strobes into a bit mask for the checksum.
    always_comb begin
        wmask = '0;
        for (int i = 0; i < STRB_W; i++) wmask[i*8 +: 8] = {8{in_wstrb[i]}};
    end

    // Beat counter, sticky burst error, checksum and saturating error count.
    always_ff @(posedge aclk) begin
        if (srst) begin
            beat_cnt  <= '0;
            burst_err <= 1'b0;
            data_sum  <= '0;
            err_cnt   <= '0;
        end else begin
            if (w_fire) begin
                data_sum <= data_sum ^ (in_wdata & wmask);
                if (aw_pop) begin
                    beat_cnt  <= '0;
                    burst_err <= 1'b0;
                end else begin
                    beat_cnt  <= beat_cnt + 8'd1;
                    burst_err <= burst_err | beat_err;
                end
            end
            if (b_push && (b_resp == RESP_SLVERR) && (err_cnt != 16'hFFFF))
                err_cnt <= err_cnt + 16'd1;
        end
    end

    axi_slv_ostd_fifo #(.WIDTH($bits(aw_ent_t)), .DEPTH(SLV_OSTDREQ_NUM)) u_aw_q (
        .aclk      (aclk),
        .srst      (srst),
        .push      (aw_push),
        .push_data (aw_push_ent),
        .pop       (aw_pop),
        .head      (aw_head),
        .full      (aw_full),
        .empty     (aw_empty)
    );

    axi_slv_ostd_fifo #(.WIDTH(B_W), .DEPTH(SLV_OSTDREQ_NUM)) u_b_q (
        .aclk      (aclk),
        .srst      (srst),
        .push      (b_push),
        .push_data (b_push_ent),
        .pop       (b_pop),
        .head      (b_head),
        .full      (b_full),
        .empty     (b_empty)
    );

endmodule

// File: tb/tb_axi_slv_wr_responder.sv
// Bench for axi_slv_wr_responder: directed scenarios plus a randomized run,
// all checked against a queue-based transaction model.
module tb_axi_slv_wr_responder;

    localparam int ID_W   = 4;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 4;
    localparam int TMO    = 400;

    logic              aclk = 1'b0;
    logic              srst = 1'b1;
    logic              in_awvalid = 1'b0;
    logic              out_awready;
    logic [ID_W-1:0]   in_awid = '0;
    logic [7:0]        in_awlen = '0;
    logic              in_wvalid = 1'b0;
    logic              out_wready;
    logic [ID_W-1:0]   in_wid = '0;
    logic [DATA_W-1:0] in_wdata = '0;
    logic [STRB_W-1:0] in_wstrb = '0;
    logic              in_wlast = 1'b0;
    logic              out_bvalid;
    logic              in_bready = 1'b1;
    logic [ID_W-1:0]   out_bid;
    logic [1:0]        out_bresp;
    logic [DATA_W-1:0] data_sum;
    logic [15:0]       err_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
    } aw_t;

    aw_t               m_aw[$];
    logic [ID_W+1:0]   exp_q[$];
    int                cur_beats = 0;
    bit                cur_bad = 0;
    logic [DATA_W-1:0] m_sum = '0;
    int                m_err = 0;
    bit                rnd_done = 0;

    always #5 aclk = ~aclk;

    axi_slv_wr_responder #(
        .AXI_ID_W(ID_W), .AXI_DATA_W(DATA_W), .SLV_OSTDREQ_NUM(DEPTH)
    ) dut (
        .aclk(aclk), .srst(srst),
        .in_awvalid(in_awvalid), .out_awready(out_awready),
        .in_awid(in_awid), .in_awlen(in_awlen),
        .in_wvalid(in_wvalid), .out_wready(out_wready),
        .in_wid(in_wid), .in_wdata(in_wdata), .in_wstrb(in_wstrb), .in_wlast(in_wlast),
        .out_bvalid(out_bvalid), .in_bready(in_bready),
        .out_bid(out_bid), .out_bresp(out_bresp),
        .data_sum(data_sum), .err_cnt(err_cnt)
    );

    // Scoreboard: a burst is good only if it has exactly len+1 beats, wlast on the
    // final one only, and every wid equal to the awid. Checked every negedge.
    task automatic monitor();
        aw_t h;
        logic [DATA_W-1:0] mask;
        bit bad;
        forever begin
            @(negedge aclk);
            if (srst) begin
                m_aw.delete(); exp_q.delete();
                cur_beats = 0; cur_bad = 0; m_sum = '0; m_err = 0;
            end else begin
                checks++;
                if (out_bvalid !== (exp_q.size() != 0)) begin
                    errors++; $display("FAIL mon_bvalid got %0b exp %0b", out_bvalid, exp_q.size() != 0);
                end
`ifndef SLV_RAND_STALL_EN
                checks++;
                if (out_awready !== (m_aw.size() < DEPTH)) begin
                    errors++; $display("FAIL mon_awready got %0b exp %0b", out_awready, m_aw.size() < DEPTH);
                end
                checks++;
                if (out_wready !== (m_aw.size() != 0 && exp_q.size() < DEPTH)) begin
                    errors++; $display("FAIL mon_wready got %0b exp %0b", out_wready,
                                       m_aw.size() != 0 && exp_q.size() < DEPTH);
                end
`endif
                checks++;
                if (data_sum !== m_sum) begin
                    errors++; $display("FAIL mon_data_sum got %h exp %h", data_sum, m_sum);
                end
                checks++;
                if (err_cnt !== 16'(m_err)) begin
                    errors++; $display("FAIL mon_err_cnt got %0d exp %0d", err_cnt, m_err);
                end
                if (out_bvalid && in_bready && exp_q.size() != 0) begin
                    checks++;
                    if ({out_bid, out_bresp} !== exp_q[0]) begin
                        errors++; $display("FAIL mon_b got id %h resp %b exp id %h resp %b",
                                           out_bid, out_bresp, exp_q[0][ID_W+1:2], exp_q[0][1:0]);
                    end
                    void'(exp_q.pop_front());
                end
                if (in_awvalid && out_awready)
                    m_aw.push_back('{id: in_awid, len: int'(in_awlen)});
                if (in_wvalid && out_wready && m_aw.size() != 0) begin
                    h = m_aw[0];
                    mask = '0;
                    for (int i = 0; i < STRB_W; i++) if (in_wstrb[i]) mask[i*8 +: 8] = 8'hFF;
                    m_sum = m_sum ^ (in_wdata & mask);
                    cur_beats++;
                    if (in_wid != h.id) cur_bad = 1;
                    if (in_wlast || cur_beats == h.len + 1) begin
                        bad = cur_bad || !(in_wlast && cur_beats == h.len + 1);
                        exp_q.push_back({h.id, bad ? 2'b10 : 2'b00});
                        if (bad && m_err < 65535) m_err++;
                        void'(m_aw.pop_front());
                        cur_beats = 0; cur_bad = 0;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    task automatic send_aw(input logic [ID_W-1:0] id, input logic [7:0] len);
        int n = 0;
        logic ok;
        in_awvalid = 1'b1; in_awid = id; in_awlen = len;
        do begin
            @(negedge aclk); ok = out_awready;
            @(posedge aclk); #1; n++;
        end while (!ok && n < TMO);
        in_awvalid = 1'b0;
        if (!ok) begin
            checks++; errors++; $display("FAIL aw_timeout id %h got no awready exp awready", id);
        end
    endtask

    task automatic send_beat(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data,
                             input logic [STRB_W-1:0] strb, input logic last);
        int n = 0;
        logic ok;
        in_wvalid = 1'b1; in_wid = id; in_wdata = data; in_wstrb = strb; in_wlast = last;
        do begin
            @(negedge aclk); ok = out_wready;
            @(posedge aclk); #1; n++;
        end while (!ok && n < TMO);
        in_wvalid = 1'b0; in_wlast = 1'b0;
        if (!ok) begin
            checks++; errors++; $display("FAIL w_timeout id %h got no wready exp wready", id);
        end
    endtask

    task automatic drain_b();
        int n = 0;
        while (exp_q.size() != 0 && n < TMO) begin @(posedge aclk); #1; n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL drain_b got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        srst = 1'b1; in_awvalid = 1'b0; in_wvalid = 1'b0; in_wlast = 1'b0;
        idle(2);
        srst = 1'b0;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        idle(3);
        checks++;
        if ({out_awready, out_wready, out_bvalid, out_bid, out_bresp, data_sum, err_cnt} !== '0) begin
            errors++; $display("FAIL reset_outputs got aw %b w %b b %b sum %h err %0d exp all 0",
                               out_awready, out_wready, out_bvalid, data_sum, err_cnt);
        end
        srst = 1'b0; #1;
        checks++;
        if (out_awready !== 1'b1 || out_wready !== 1'b0 || out_bvalid !== 1'b0) begin
            errors++; $display("FAIL reset_release got aw %b w %b b %b exp 1 0 0",
                               out_awready, out_wready, out_bvalid);
        end
    endtask

    task automatic test_single();
        in_bready = 1'b1;
        send_aw(4'h5, 8'd3);
        for (int i = 0; i < 4; i++) send_beat(4'h5, $urandom, 4'hF, i == 3);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h5 || out_bresp !== 2'b00) begin
            errors++; $display("FAIL single_b got v %b id %h resp %b exp 1 5 00", out_bvalid, out_bid, out_bresp);
        end
        idle(2);
        checks++;
        if (err_cnt !== 16'd0) begin errors++; $display("FAIL single_err got %0d exp 0", err_cnt); end
    endtask

    task automatic test_outstanding();
        in_bready = 1'b1;
        for (int i = 0; i < 4; i++) send_aw(ID_W'(i), 8'd1);
        in_awvalid = 1'b1; in_awid = 4'h4; in_awlen = 8'd1;
        repeat (3) begin
            @(negedge aclk);
            checks++;
            if (out_awready !== 1'b0) begin errors++; $display("FAIL ostd_stall got awready %b exp 0", out_awready); end
        end
        @(posedge aclk); #1;
        fork
            send_aw(4'h4, 8'd1);
            for (int b = 0; b < 5; b++)
                for (int k = 0; k < 2; k++) send_beat(ID_W'(b), $urandom, 4'hF, k == 1);
        join
        drain_b();
    endtask

    task automatic test_early_last();
        do_reset();
        in_bready = 1'b1;
        send_aw(4'h1, 8'd7);
        send_aw(4'h6, 8'd1);
        for (int i = 0; i < 3; i++) send_beat(4'h1, $urandom, 4'hF, i == 2);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h1 || out_bresp !== 2'b10) begin
            errors++; $display("FAIL early_b got v %b id %h resp %b exp 1 1 10", out_bvalid, out_bid, out_bresp);
        end
        send_beat(4'h6, $urandom, 4'hF, 1'b0);
        send_beat(4'h6, $urandom, 4'hF, 1'b1);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h6 || out_bresp !== 2'b00) begin
            errors++; $display("FAIL early_next got v %b id %h resp %b exp 1 6 00", out_bvalid, out_bid, out_bresp);
        end
        idle(1);
        checks++;
        if (err_cnt !== 16'd1) begin errors++; $display("FAIL early_err got %0d exp 1", err_cnt); end
    endtask

    task automatic test_wid_mismatch();
        in_bready = 1'b1;
        send_aw(4'h2, 8'd0);
        send_beat(4'h3, $urandom, 4'hF, 1'b1);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h2 || out_bresp !== 2'b10) begin
            errors++; $display("FAIL wid_b got v %b id %h resp %b exp 1 2 10", out_bvalid, out_bid, out_bresp);
        end
        idle(1);
        checks++;
        if (err_cnt !== 16'd2) begin errors++; $display("FAIL wid_err got %0d exp 2", err_cnt); end
    endtask

    task automatic test_late_last();
        in_bready = 1'b1;
        send_aw(4'h9, 8'd1);
        send_aw(4'hA, 8'd0);
        send_beat(4'h9, $urandom, 4'hF, 1'b0);
        send_beat(4'h9, $urandom, 4'hF, 1'b0);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h9 || out_bresp !== 2'b10) begin
            errors++; $display("FAIL late_b got v %b id %h resp %b exp 1 9 10", out_bvalid, out_bid, out_bresp);
        end
        send_beat(4'hA, $urandom, 4'hF, 1'b1);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'hA || out_bresp !== 2'b00) begin
            errors++; $display("FAIL late_next got v %b id %h resp %b exp 1 a 00", out_bvalid, out_bid, out_bresp);
        end
        drain_b();
    endtask

    task automatic test_backpressure();
        do_reset();
        in_bready = 1'b0;
        for (int i = 0; i < 4; i++) send_aw(ID_W'(i), 8'd0);
        for (int i = 1; i <= 4; i++) send_beat(ID_W'(i-1), DATA_W'(i), 4'hF, 1'b1);
        send_aw(4'h4, 8'd0);
        repeat (3) begin
            @(negedge aclk);
            checks++;
            if (out_wready !== 1'b0 || out_bvalid !== 1'b1) begin
                errors++; $display("FAIL bp_full got wready %b bvalid %b exp 0 1", out_wready, out_bvalid);
            end
        end
        checks++;
        if (data_sum !== 32'd4) begin errors++; $display("FAIL bp_sum got %h exp 00000004", data_sum); end
        @(posedge aclk); #1;
        in_bready = 1'b1;
        drain_b();
        @(negedge aclk);
        checks++;
        if (out_wready !== 1'b1) begin errors++; $display("FAIL bp_resume got wready %b exp 1", out_wready); end
        @(posedge aclk); #1;
        send_beat(4'h4, 32'h1234_5678, 4'h1, 1'b1);
        checks++;
        if (data_sum !== 32'h0000_007C) begin errors++; $display("FAIL bp_strb_sum got %h exp 0000007c", data_sum); end
        drain_b();
    endtask

    task automatic test_srst_mid();
        do_reset();
        in_bready = 1'b0;
        send_aw(4'h3, 8'd0); send_beat(4'h3, 32'hDEAD_BEEF, 4'hF, 1'b1);
        send_aw(4'h5, 8'd0); send_beat(4'h6, 32'h0BAD_F00D, 4'hF, 1'b1);
        send_aw(4'h7, 8'd3);
        send_beat(4'h7, $urandom, 4'hF, 1'b0);
        send_beat(4'h7, $urandom, 4'hF, 1'b0);
        idle(1);
        checks++;
        if (out_bvalid !== 1'b1 || err_cnt !== 16'd1) begin
            errors++; $display("FAIL srst_pre got bvalid %b err %0d exp 1 1", out_bvalid, err_cnt);
        end
        srst = 1'b1;
        @(posedge aclk); #1;
        srst = 1'b0; #1;
        checks++;
        if (out_bvalid !== 1'b0 || out_awready !== 1'b1 || out_wready !== 1'b0 ||
            data_sum !== '0 || err_cnt !== 16'd0) begin
            errors++; $display("FAIL srst_post got b %b aw %b w %b sum %h err %0d exp 0 1 0 0 0",
                               out_bvalid, out_awready, out_wready, data_sum, err_cnt);
        end
        in_bready = 1'b1;
        @(posedge aclk); #1;
        send_aw(4'h8, 8'd0);
        send_beat(4'h8, $urandom, 4'hF, 1'b1);
        checks++;
        if (out_bvalid !== 1'b1 || out_bid !== 4'h8 || out_bresp !== 2'b00) begin
            errors++; $display("FAIL srst_after got v %b id %h resp %b exp 1 8 00", out_bvalid, out_bid, out_bresp);
        end
        drain_b();
    endtask

    task automatic test_random();
        localparam int NB = 40;
        logic [ID_W-1:0] ids[NB];
        int lens[NB];
        int modes[NB];
        do_reset();
        for (int b = 0; b < NB; b++) begin
            ids[b]  = ID_W'($urandom);
            lens[b] = $urandom_range(0, 5);
            modes[b] = ($urandom_range(0, 9) < 6) ? 0 : $urandom_range(1, 3);
            if (modes[b] == 1 && lens[b] == 0) modes[b] = 0;
        end
        rnd_done = 0;
        fork
            begin
                fork
                    for (int b = 0; b < NB; b++) begin
                        idle($urandom_range(0, 2));
                        send_aw(ids[b], 8'(lens[b]));
                    end
                    for (int b = 0; b < NB; b++) begin
                        int nbeat = lens[b] + 1;
                        int bad_beat = $urandom_range(0, lens[b]);
                        if (modes[b] == 1) nbeat = $urandom_range(1, lens[b]);
                        for (int k = 0; k < nbeat; k++) begin
                            logic [ID_W-1:0] wid = ids[b];
                            logic last = (k == nbeat - 1) && (modes[b] != 2);
                            if (modes[b] == 3 && k == bad_beat) wid = ids[b] ^ 4'h1;
                            idle($urandom_range(0, 1));
                            send_beat(wid, $urandom, STRB_W'($urandom), last);
                        end
                    end
                join
                rnd_done = 1;
            end
            while (!rnd_done) begin
                in_bready = 1'($urandom_range(0, 1));
                @(posedge aclk); #1;
            end
        join
        in_bready = 1'b1;
        drain_b();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_outstanding();
        test_early_last();
        test_wid_mismatch();
        test_late_last();
        test_backpressure();
        test_srst_mid();
        test_random();
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
